// File: rtl/bike_pkg.sv
// Shared types and constants for the bike display formatter: mode encoding,
// FSM states, ASCII constants, clamp limits and the blanking-protection helper.
package bike_pkg;

  typedef enum logic [1:0] {
    MODE_DAY,
    MODE_AVS,
    MODE_TIM,
    MODE_MAX
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FORMAT
  } fmt_state_t;

  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [7:0]  ASCII_DASH = 8'h2D;
  localparam int unsigned LOWER_MAX  = 9999;
  localparam int unsigned UPPER_MAX  = 99;

  // Index (0 = lower1000) of the first lower digit that is never blanked.
  function automatic int unsigned protect_pos(input mode_t m);
    case (m)
      MODE_DAY: return 1;
      MODE_AVS: return 2;
      MODE_TIM: return 1;
      default:  return 3;
    endcase
  endfunction

endpackage

// File: rtl/bike_ascii_formatter_if.sv
// Conversion handshake between the mode controller (master) and the
// ASCII formatter (slave): request, ride data, mode flags and display chars.
interface bike_ascii_formatter_if;
  logic       start;
  logic [6:0] max_speed;
  logic [6:0] speed;
  logic [13:0] distance;
  logic [9:0] avg_speed;
  logic [6:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       AVS, DAY, MAX, TIM;
  logic [7:0] lower1000, lower0100, lower0010, lower0001;
  logic [7:0] upper10, upper01;
  logic       valid_out;

  modport master (
    output start, max_speed, speed, distance, avg_speed, hours, minutes, seconds,
    output AVS, DAY, MAX, TIM,
    input  lower1000, lower0100, lower0010, lower0001, upper10, upper01, valid_out
  );

  modport slave (
    input  start, max_speed, speed, distance, avg_speed, hours, minutes, seconds,
    input  AVS, DAY, MAX, TIM,
    output lower1000, lower0100, lower0010, lower0001, upper10, upper01, valid_out
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: load captures the binary value, then one bit per cycle
// for WIDTH cycles; done flags the cycle whose closing edge completes the result.
module bin2bcd_serial #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    sh;
  logic [CW-1:0]       count;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh    <= '0;
      bcd   <= '0;
      count <= '0;
    end else if (load) begin
      sh    <= bin_in;
      bcd   <= '0;
      count <= CW'(WIDTH);
    end else if (busy) begin
      bcd   <= {adj[4*DIGITS-2:0], sh[WIDTH-1]};
      sh    <= {sh[WIDTH-2:0], 1'b0};
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);
  assign done = (count == CW'(1));
endmodule

// File: rtl/bike_ascii_formatter.sv
// Captures ride data on start, converts lower (4-digit) and upper (2-digit)
// fields to ASCII with leading-zero blanking. Option: BIKE_FMT_OVERFLOW_DASH_EN.
import bike_pkg::*;

module bike_ascii_formatter #(
  parameter int unsigned LOWER_W    = 14,
  parameter int unsigned UPPER_W    = 7,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                   clock,
  input  logic                   reset,
  bike_ascii_formatter_if.slave  bus
);
  fmt_state_t         state, state_nx;
  mode_t              mode_q, mode_nx;
  logic [13:0]        dist_c, tim_val, h14, lower14;
  logic [6:0]         hrs_c, spd_c;
  logic [LOWER_W-1:0] lower_val;
  logic [UPPER_W-1:0] upper_val;
  logic [15:0]        lo_bcd;
  logic [7:0]         up_bcd;
  logic               lo_busy, lo_done, up_busy, up_done;
  logic               load, fmt_fire;
  logic [7:0]         lo_ch [4];
  logic [7:0]         up_ch1, up_ch0;
  logic               unused_bits;

  assign unused_bits = ^{bus.seconds, lo_busy, up_busy, up_done};

  // Mode only follows an unambiguous indicator; blink patterns keep the old one.
  always_comb begin
    mode_nx = mode_q;
    case ({bus.AVS, bus.DAY, bus.MAX, bus.TIM})
      4'b1000: mode_nx = MODE_AVS;
      4'b0100: mode_nx = MODE_DAY;
      4'b0010: mode_nx = MODE_MAX;
      4'b0001: mode_nx = MODE_TIM;
      default: ;
    endcase
  end

  always_comb begin
    dist_c  = (bus.distance > 14'(LOWER_MAX)) ? 14'(LOWER_MAX) : bus.distance;
    hrs_c   = (bus.hours > 7'(UPPER_MAX)) ? 7'(UPPER_MAX) : bus.hours;
    spd_c   = (bus.speed > 7'(UPPER_MAX)) ? 7'(UPPER_MAX) : bus.speed;
    h14     = 14'(hrs_c);
    tim_val = (h14 << 6) + (h14 << 5) + (h14 << 2) + 14'(bus.minutes);
    case (mode_nx)
      MODE_DAY: lower14 = dist_c;
      MODE_AVS: lower14 = 14'(bus.avg_speed);
      MODE_TIM: lower14 = tim_val;
      default:  lower14 = 14'(bus.max_speed);
    endcase
    lower_val = LOWER_W'(lower14);
    upper_val = UPPER_W'(spd_c);
  end

  assign load = (state == LOAD);

  bin2bcd_serial #(.WIDTH(LOWER_W), .DIGITS(4)) u_lower (
    .clock(clock), .reset(reset), .load(load), .bin_in(lower_val),
    .busy(lo_busy), .done(lo_done), .bcd(lo_bcd)
  );

  bin2bcd_serial #(.WIDTH(UPPER_W), .DIGITS(2)) u_upper (
    .clock(clock), .reset(reset), .load(load), .bin_in(upper_val),
    .busy(up_busy), .done(up_done), .bcd(up_bcd)
  );

  // A start in any state restarts at LOAD, which also suppresses a pending FORMAT.
  always_comb begin
    state_nx = state;
    if (bus.start) begin
      state_nx = LOAD;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        LOAD:    state_nx = SHIFT;
        SHIFT:   if (lo_done) state_nx = FORMAT;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign fmt_fire = (state == FORMAT) && !bus.start;

`ifdef BIKE_FMT_OVERFLOW_DASH_EN
  logic ovf_lo_q, ovf_up_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_lo_q <= 1'b0;
      ovf_up_q <= 1'b0;
    end else if (load) begin
      ovf_lo_q <= ((mode_nx == MODE_DAY) && (bus.distance > 14'(LOWER_MAX))) ||
                  ((mode_nx == MODE_TIM) && (bus.hours > 7'(UPPER_MAX)));
      ovf_up_q <= (bus.speed > 7'(UPPER_MAX));
    end
  end
`endif

  always_comb begin
    logic       run;
    logic [3:0] dig;
    run = 1'b1;
    dig = 4'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      dig      = lo_bcd[4*(3-i) +: 4];
      run      = run && (dig == 4'd0);
      lo_ch[i] = (run && (i < protect_pos(mode_q))) ? BLANK_CHAR : ASCII_ZERO + {4'd0, dig};
    end
    up_ch1 = (up_bcd[7:4] == 4'd0) ? BLANK_CHAR : ASCII_ZERO + {4'd0, up_bcd[7:4]};
    up_ch0 = ASCII_ZERO + {4'd0, up_bcd[3:0]};
`ifdef BIKE_FMT_OVERFLOW_DASH_EN
    if (ovf_lo_q) begin
      for (int unsigned i = 0; i < 4; i++) lo_ch[i] = ASCII_DASH;
    end
    if (ovf_up_q) begin
      up_ch1 = ASCII_DASH;
      up_ch0 = ASCII_DASH;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mode_q        <= MODE_DAY;
      bus.valid_out <= 1'b0;
      bus.lower1000 <= BLANK_CHAR;
      bus.lower0100 <= BLANK_CHAR;
      bus.lower0010 <= BLANK_CHAR;
      bus.lower0001 <= BLANK_CHAR;
      bus.upper10   <= BLANK_CHAR;
      bus.upper01   <= BLANK_CHAR;
    end else begin
      state         <= state_nx;
      bus.valid_out <= fmt_fire;
      if (load) mode_q <= mode_nx;
      if (fmt_fire) begin
        bus.lower1000 <= lo_ch[0];
        bus.lower0100 <= lo_ch[1];
        bus.lower0010 <= lo_ch[2];
        bus.lower0001 <= lo_ch[3];
        bus.upper10   <= up_ch1;
        bus.upper01   <= up_ch0;
      end
    end
  end
endmodule

// File: tb/tb_bike_ascii_formatter.sv
// Directed bench for bike_ascii_formatter: latency, blanking per mode, mode
// latch, clamping/dash option, restart and reset behaviour.
module tb_bike_ascii_formatter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bike_ascii_formatter_if bus ();

  bike_ascii_formatter #(.LOWER_W(14), .UPPER_W(7), .BLANK_CHAR(8'h20)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_chars(input string tag, input logic [7:0] l3, l2, l1, l0, u1, u0);
    check({tag, "_l1000"}, bus.lower1000, l3);
    check({tag, "_l0100"}, bus.lower0100, l2);
    check({tag, "_l0010"}, bus.lower0010, l1);
    check({tag, "_l0001"}, bus.lower0001, l0);
    check({tag, "_u10"},   bus.upper10,   u1);
    check({tag, "_u01"},   bus.upper01,   u0);
  endtask

  task automatic set_mode(input logic a, d, m, t);
    bus.AVS = a; bus.DAY = d; bus.MAX = m; bus.TIM = t;
  endtask

  // Start sampled at edge k; checks valid low at k+15, result at k+16, low at k+17.
  task automatic convert(input string tag, input logic [7:0] l3, l2, l1, l0, u1, u0);
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (15) @(posedge clock);
    #1 check({tag, "_v15"}, 8'(bus.valid_out), 8'd0);
    @(posedge clock); #1;
    check({tag, "_v16"}, 8'(bus.valid_out), 8'd1);
    check_chars(tag, l3, l2, l1, l0, u1, u0);
    @(posedge clock); #1;
    check({tag, "_v17"}, 8'(bus.valid_out), 8'd0);
    check_chars({tag, "_hold"}, l3, l2, l1, l0, u1, u0);
  endtask

  initial begin
    int pulses;
    bus.start = 1'b0; bus.max_speed = '0; bus.speed = '0; bus.distance = '0;
    bus.avg_speed = '0; bus.hours = '0; bus.minutes = '0; bus.seconds = '0;
    set_mode(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset with start pulses inside it
    repeat (2) @(posedge clock);
    #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    @(posedge clock); #1;
    check_chars("rst", 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20);
    check("rst_v", 8'(bus.valid_out), 8'd0);
    bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0; reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (bus.valid_out) pulses++;
    end
    check("rst_start_nov", 8'(pulses), 8'd0);

    bus.distance = 14'd1234; bus.speed = 7'd25;
    convert("day1234", 8'h31, 8'h32, 8'h33, 8'h34, 8'h32, 8'h35);
    bus.distance = 14'd5;
    convert("day5", 8'h20, 8'h30, 8'h30, 8'h35, 8'h32, 8'h35);

    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    bus.max_speed = 7'd7; bus.speed = 7'd0;
    convert("max7", 8'h20, 8'h20, 8'h20, 8'h37, 8'h20, 8'h30);

    set_mode(1'b0, 1'b0, 1'b0, 1'b1);
    bus.hours = 7'd1; bus.minutes = 6'd7;
    convert("tim107", 8'h20, 8'h31, 8'h30, 8'h37, 8'h20, 8'h30);
    set_mode(1'b1, 1'b1, 1'b1, 1'b1);
    bus.avg_speed = 10'd555;
    convert("blink", 8'h20, 8'h31, 8'h30, 8'h37, 8'h20, 8'h30);

    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    convert("avs555", 8'h20, 8'h35, 8'h35, 8'h35, 8'h20, 8'h30);
    bus.avg_speed = 10'd5;
    convert("avs5", 8'h20, 8'h20, 8'h30, 8'h35, 8'h20, 8'h30);
    set_mode(1'b0, 1'b0, 1'b0, 1'b0);
    bus.avg_speed = 10'd42; bus.distance = 14'd1234;
    convert("none42", 8'h20, 8'h20, 8'h34, 8'h32, 8'h20, 8'h30);

    set_mode(1'b0, 1'b1, 1'b0, 1'b0);
    bus.distance = 14'd12000; bus.speed = 7'd120;
`ifdef BIKE_FMT_OVERFLOW_DASH_EN
    convert("dayovf", 8'h2D, 8'h2D, 8'h2D, 8'h2D, 8'h2D, 8'h2D);
`else
    convert("dayovf", 8'h39, 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);
`endif
    set_mode(1'b0, 1'b0, 1'b0, 1'b1);
    bus.hours = 7'd120; bus.minutes = 6'd30; bus.speed = 7'd88;
`ifdef BIKE_FMT_OVERFLOW_DASH_EN
    convert("timovf", 8'h2D, 8'h2D, 8'h2D, 8'h2D, 8'h38, 8'h38);
`else
    convert("timovf", 8'h39, 8'h39, 8'h33, 8'h30, 8'h38, 8'h38);
`endif

    // Restart: start at k, second start at k+5 with new speed
    set_mode(1'b0, 1'b1, 1'b0, 1'b0);
    bus.distance = 14'd1234; bus.speed = 7'd10;
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 21; i++) begin
      if (i == 5) begin
        bus.start = 1'b1; bus.speed = 7'd40;
      end
      @(posedge clock); #1;
      if (i == 5) bus.start = 1'b0;
      if (i < 21 && bus.valid_out) pulses++;
    end
    check("restart_early_v", 8'(pulses), 8'd0);
    check("restart_v21", 8'(bus.valid_out), 8'd1);
    check_chars("restart", 8'h31, 8'h32, 8'h33, 8'h34, 8'h34, 8'h30);

    // Reset mid-conversion
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check_chars("midrst", 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (bus.valid_out) pulses++;
    end
    check("midrst_nov", 8'(pulses), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
